// File: rtl/median_feeder.sv
// median_feeder: gathers a 3x3 pixel window, replays it as a burst to MEDIAN, returns the median
module median_feeder #(
  parameter int width   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] PIX_IN,
  input  logic             PIX_VALID,
  output logic             PIX_READY,
  output logic [width-1:0] MED_DI,
  output logic             MED_DSI,
  input  logic [width-1:0] MED_DO,
  input  logic             MED_DSO,
  output logic [width-1:0] RES,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic             ERR
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {LOAD, SEND, WAIT, HOLD} state_t;
  state_t state, nxt;
  logic [width-1:0] pix_buf [9];
  logic [3:0] wcnt, rcnt;
  logic [TW-1:0] tcnt;
  logic accept, last_acc, tmo;
  assign accept    = state == LOAD && PIX_VALID;
  assign last_acc  = accept && wcnt == 4'd8;
  assign tmo       = tcnt == TW'(TIMEOUT - 1);
  assign PIX_READY = state == LOAD;
  // state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= LOAD;
    else state <= nxt;
  // next-state decode
  always_comb begin
    nxt = state;
    case (state)
      LOAD: nxt = last_acc ? SEND : LOAD;
      SEND: nxt = rcnt == 4'd8 ? WAIT : SEND;
      WAIT: nxt = MED_DSO ? HOLD : (tmo ? LOAD : WAIT);
      HOLD: nxt = RES_READY ? LOAD : HOLD;
      default: nxt = LOAD;
    endcase
  end
  // window storage; contents need no reset since every window is fully rewritten before replay
  always_ff @(posedge CLK)
    if (accept) pix_buf[wcnt] <= PIX_IN;
  // counters, burst outputs, result capture and sticky timeout flag
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wcnt      <= '0;
      rcnt      <= '0;
      tcnt      <= '0;
      MED_DI    <= '0;
      MED_DSI   <= 1'b0;
      RES       <= '0;
      RES_VALID <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      if (accept) wcnt <= last_acc ? 4'd0 : wcnt + 4'd1;
      if (last_acc) begin
        MED_DSI <= 1'b1;
        MED_DI  <= pix_buf[0];
      end
      if (state == SEND) begin
        if (rcnt == 4'd8) begin
          MED_DSI <= 1'b0;
          rcnt    <= '0;
          tcnt    <= '0;
        end else begin
          rcnt   <= rcnt + 4'd1;
          MED_DI <= pix_buf[rcnt + 4'd1];
        end
      end
      if (state == WAIT) begin
        tcnt <= tcnt + 1'b1;
        if (MED_DSO) begin
          RES       <= MED_DO;
          RES_VALID <= 1'b1;
        end else if (tmo) ERR <= 1'b1;
      end
      if (state == HOLD && RES_READY) RES_VALID <= 1'b0;
    end
endmodule

// File: tb/tb_median_feeder.sv
// tb_median_feeder: directed checks of window load, burst replay, result handshake and timeout
module tb_median_feeder;
  logic       CLK = 0, RST = 0, run = 0;
  logic [7:0] PIX_IN = 0, MED_DO = 0;
  logic       PIX_VALID = 0, MED_DSO = 0, RES_READY = 1;
  logic       PIX_READY, MED_DSI, RES_VALID, ERR;
  logic [7:0] MED_DI, RES;
  int checks = 0, errors = 0;
  logic [7:0] w1 [9] = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
  logic [7:0] w2 [9] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
  logic [7:0] w3 [9] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
  logic [7:0] w4 [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};

  median_feeder #(.width(8), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .MED_DI(MED_DI), .MED_DSI(MED_DSI), .MED_DO(MED_DO), .MED_DSO(MED_DSO),
    .RES(RES), .RES_VALID(RES_VALID), .RES_READY(RES_READY), .ERR(ERR)
  );

  always begin
    #5;
    if (run) CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] p [9], input bit gapped);
    for (int i = 0; i < 9; i++) begin
      PIX_VALID = 1;
      PIX_IN = p[i];
      @(negedge CLK);
      if (gapped && i < 8) begin
        PIX_VALID = 0;
        @(negedge CLK);
      end
    end
    PIX_VALID = 0;
  endtask

  task automatic burst(input logic [7:0] p [9], input bit spur);
    int n = 0;
    chk("dsi_latency", MED_DSI, 1);
    while (MED_DSI === 1'b1 && n < 20) begin
      if (n < 9) chk("di_beat", MED_DI, p[n]);
      MED_DSO = spur && n == 3;
      MED_DO = 8'hEE;
      n++;
      @(negedge CLK);
    end
    MED_DSO = 0;
    chk("burst_len", n, 9);
    chk("di_hold", MED_DI, p[8]);
  endtask

  task automatic answer(input int n, input logic [7:0] v);
    repeat (n) @(negedge CLK);
    MED_DSO = 1;
    MED_DO = v;
    @(negedge CLK);
    MED_DSO = 0;
    chk("res_valid", RES_VALID, 1);
    chk("res", RES, v);
  endtask

  initial begin
    #3 RST = 1;
    #1;
    chk("rst_pix_ready", PIX_READY, 1);
    chk("rst_dsi", MED_DSI, 0);
    chk("rst_res_valid", RES_VALID, 0);
    chk("rst_err", ERR, 0);
    chk("rst_res", RES, 0);
    run = 1;
    @(negedge CLK);
    RST = 0;
    // basic window, result drained immediately
    push(w1, 0);
    burst(w1, 0);
    answer(9, 8'd5);
    @(negedge CLK);
    chk("basic_drain_valid", RES_VALID, 0);
    chk("basic_drain_ready", PIX_READY, 1);
    // gapped input with result backpressure
    push(w2, 1);
    burst(w2, 0);
    RES_READY = 0;
    answer(3, 8'd50);
    begin
      int bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        if (RES_VALID !== 1 || RES !== 8'd50 || PIX_READY !== 0) bad++;
      end
      chk("backpressure_hold", bad, 0);
    end
    RES_READY = 1;
    @(negedge CLK);
    chk("bp_release_ready", PIX_READY, 1);
    chk("bp_release_valid", RES_VALID, 0);
    // DSO on the last WAIT cycle beats the timeout
    push(w3, 0);
    burst(w3, 0);
    answer(15, 8'hA5);
    chk("edge_dso_err", ERR, 0);
    @(negedge CLK);
    // spurious DSO during SEND is ignored
    push(w1, 0);
    burst(w1, 1);
    chk("spur_res_valid", RES_VALID, 0);
    chk("spur_res", RES, 8'hA5);
    answer(2, 8'd5);
    @(negedge CLK);
    // timeout with no DSO
    push(w2, 0);
    burst(w2, 0);
    begin
      int rv = 0;
      for (int i = 0; i < 15; i++) begin
        if (RES_VALID !== 0) rv++;
        @(negedge CLK);
      end
      chk("tmo_err_early", ERR, 0);
      chk("tmo_ready_early", PIX_READY, 0);
      @(negedge CLK);
      chk("tmo_err", ERR, 1);
      chk("tmo_ready", PIX_READY, 1);
      chk("tmo_res_valid", rv + RES_VALID, 0);
      chk("tmo_res", RES, 8'd5);
    end
    // normal window after timeout keeps ERR sticky
    push(w3, 0);
    burst(w3, 0);
    answer(4, 8'hA5);
    chk("err_sticky", ERR, 1);
    @(negedge CLK);
    // reset in the middle of a burst
    push(w4, 0);
    for (int i = 0; i < 4; i++) begin
      chk("pre_rst_di", MED_DI, w4[i]);
      @(negedge CLK);
    end
    RST = 1;
    #1;
    chk("midrst_dsi", MED_DSI, 0);
    chk("midrst_ready", PIX_READY, 1);
    chk("midrst_err", ERR, 0);
    @(negedge CLK);
    RST = 0;
    push(w1, 0);
    burst(w1, 0);
    answer(1, 8'd5);
    @(negedge CLK);
    chk("final_ready", PIX_READY, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/median_feeder.md
Name: median_feeder

Overview:
- Initiator side of the MEDIAN pixel-burst interface.
- Collects 9 pixels of a 3x3 window from an upstream valid/ready stream into a local buffer.
- Replays them to the MEDIAN block as a contiguous 9-cycle DI/DSI burst, then waits for the DSO strobe and captures DO.
- Returns the median on a valid/ready result port; a watchdog flags a missing DSO.

Parameters:
- width, 8, pixel bit width (matches MEDIAN width).
- TIMEOUT, 64, max cycles in WAIT before declaring a lost result (>= 2).

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- PIX_IN  in  width  upstream pixel.
- PIX_VALID  in  1  upstream pixel valid.
- PIX_READY  out  1  feeder accepts a pixel this cycle.
- MED_DI  out  width  to MEDIAN DI.
- MED_DSI  out  1  to MEDIAN DSI, burst strobe.
- MED_DO  in  width  from MEDIAN DO.
- MED_DSO  in  1  from MEDIAN DSO, result strobe.
- RES  out  width  captured median.
- RES_VALID  out  1  RES is valid.
- RES_READY  in  1  downstream accepts RES.
- ERR  out  1  sticky timeout flag.

Behaviour:
- Reset (async, RST=1): state=LOAD, all counters 0, PIX_READY=1, MED_DSI=0, MED_DI=0, RES=0, RES_VALID=0, ERR=0. Buffer contents undefined.
- Reset mid-burst: MED_DSI drops immediately, the partial window is discarded, and the block restarts in LOAD.
- All outputs are registered except PIX_READY, which is decoded from state (1 only in LOAD).
- States: LOAD, SEND, WAIT, HOLD.
- LOAD:
  - Each cycle with PIX_VALID=1, write PIX_IN to buf[wcnt] and increment wcnt (0..8).
  - On the accept with wcnt=8: wcnt<=0, go to SEND.
  - Cycles with PIX_VALID=0 hold wcnt; gaps in the input stream are allowed.
- SEND:
  - MED_DSI=1 for exactly 9 consecutive cycles, starting the cycle after the 9th accept.
  - MED_DI=buf[rcnt], with rcnt 0..8 in buffer write order.
  - After the 9th beat: MED_DSI=0, MED_DI holds its last value, rcnt<=0, tcnt<=0, go to WAIT.
  - MED_DSO is ignored in SEND.
- WAIT:
  - tcnt increments each cycle.
  - If MED_DSO=1: RES<=MED_DO, RES_VALID<=1 next cycle, go to HOLD.
  - If tcnt==TIMEOUT-1 with no DSO: ERR<=1, RES and RES_VALID unchanged, go to LOAD.
  - DSO on the same cycle as tcnt==TIMEOUT-1: DSO wins and ERR is not set.
- HOLD:
  - RES_VALID=1 and RES stable until a cycle with RES_READY=1.
  - That cycle: RES_VALID<=0, go to LOAD.
  - MED_DSO in HOLD is ignored and does not overwrite RES.
  - PIX_READY=0, so no new pixels are accepted until the result drains.
- ERR stays 1 until RST and does not block operation.
- Counters: wcnt/rcnt are 4 bits (values 0..8, never wrap past 8); tcnt is $clog2(TIMEOUT) bits.
- Latency: last pixel accept to first MED_DSI=1 is 1 cycle; burst is 9 cycles; DSO to RES_VALID is 1 cycle.

Test Plan:
- Reset values: assert RST mid-cycle, no clock -> PIX_READY=1, MED_DSI=0, RES_VALID=0, ERR=0 immediately.
- Basic window: push 9,1,8,2,7,3,6,4,5 back-to-back, stub MEDIAN answers 5 with DSO 10 cycles after DSI falls -> MED_DSI high exactly 9 cycles with MED_DI=9,1,...,5 in order; RES=5, RES_VALID=1 one cycle after DSO.
- Gapped input and backpressure:
  - PIX_VALID toggling 1/0 -> burst still contiguous.
  - Hold RES_READY=0 for 20 cycles -> RES_VALID stays 1, RES stable, PIX_READY=0 throughout.
  - Then RES_READY=1 -> back to LOAD next cycle.
- Timeout: TIMEOUT=16, stub never raises DSO -> ERR=1 exactly 16 cycles into WAIT, RES_VALID never rises, PIX_READY=1 next cycle; a following window with DSO completes normally with ERR still 1.
- Boundary: DSO asserted on the cycle tcnt=TIMEOUT-1 -> result captured, ERR=0; spurious DSO during SEND -> ignored, RES unchanged.
- Reset mid-SEND after 4 beats -> MED_DSI=0 at once; a new 9-pixel window replays only the new pixels.
